// File: rtl/dts_align_ctrl.sv
// dts_align_ctrl: measures per-stream sync skew across N DTS offsetter FIFOs and
// issues delay pulses to the early streams until every sync lands on one cycle.
// Optional feature macro: DTS_ALIGN_AUTO_RELOCK_EN (lock loss re-measures
// and counts a relock, instead of raising an error).
module dts_align_ctrl #(
    parameter int N_STREAMS       = 4,
    parameter int MUX_FACTOR_BITS = 0,
    parameter int MAX_OFFSET      = 63,
    parameter int HOLDOFF         = 8,
    parameter int SYNC_TIMEOUT    = 65535,
    parameter int MAX_RETRY       = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [N_STREAMS-1:0] sync,
    input  logic [N_STREAMS-1:0] almost_full,
    output logic [N_STREAMS-1:0] delay,
    output logic                 locked,
    output logic                 error,
    output logic [1:0]           err_code,
    output logic [2:0]           state,
    output logic [15:0]          relock_cnt
);
    localparam int TW = $clog2(MAX_OFFSET + 1);
    localparam int IW = $clog2(SYNC_TIMEOUT + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam int HW = $clog2(HOLDOFF + 1);

    localparam logic [TW-1:0] MAX_T        = TW'(MAX_OFFSET);
    localparam logic [TW-1:0] GRAN_MASK    = TW'((1 << MUX_FACTOR_BITS) - 1);
    localparam logic [IW-1:0] TIMEOUT_LAST = IW'(SYNC_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRY);
    localparam logic [HW-1:0] HOLD_LAST    = HW'(HOLDOFF - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_MEASURE = 3'd1,
        S_PULSE   = 3'd2,
        S_SETTLE  = 3'd3,
        S_LOCKED  = 3'd4,
        S_ERROR   = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [N_STREAMS-1:0]   seen_q, seen_d;
    logic                   win_act_q, win_act_d;
    logic [TW-1:0]          win_cnt_q, win_cnt_d;
    logic [IW-1:0]          idle_cnt_q, idle_cnt_d;
    logic [RW-1:0]          retry_q, retry_d;
    logic [HW-1:0]          hold_q, hold_d;
    logic [1:0]             err_code_q, err_code_d;
    logic [15:0]            relock_q, relock_d;
    logic [TW-1:0]          t_q [N_STREAMS];
    logic [TW-1:0]          t_d [N_STREAMS];
    logic [TW-1:0]          pulses_q [N_STREAMS];
    logic [TW-1:0]          pulses_d [N_STREAMS];

    logic [N_STREAMS-1:0]   pmask;
    logic                   af_hit;
    logic [TW-1:0]          t_max;
    logic [TW-1:0]          off_v;
    logic                   close;
    logic                   meas_clr;
    logic                   all_zero;
    logic                   bad_gran;

    // Per-stream pending-pulse flags and the pulse outputs themselves; a full
    // FIFO on a pulsed stream suppresses the whole pulse on that same cycle.
    generate
        for (genvar gi = 0; gi < N_STREAMS; gi++) begin : g_stream
            assign pmask[gi] = |pulses_q[gi];
            assign delay[gi] = (state_q == S_PULSE) && enable && pmask[gi] && !af_hit;
        end
    endgenerate

    assign af_hit     = |(almost_full & pmask);
    assign locked     = (state_q == S_LOCKED);
    assign error      = (state_q == S_ERROR);
    assign err_code   = err_code_q;
    assign state      = state_q;
    assign relock_cnt = relock_q;

    // Next-state and datapath: window measurement, pulse scheduling, lock watch.
    always_comb begin
        state_d    = state_q;
        seen_d     = seen_q;
        win_act_d  = win_act_q;
        win_cnt_d  = win_cnt_q;
        idle_cnt_d = idle_cnt_q;
        retry_d    = retry_q;
        hold_d     = hold_q;
        err_code_d = err_code_q;
        relock_d   = relock_q;
        t_d        = t_q;
        pulses_d   = pulses_q;
        t_max      = '0;
        off_v      = '0;
        close      = 1'b0;
        meas_clr   = 1'b0;
        all_zero   = 1'b1;
        bad_gran   = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d  = S_MEASURE;
                meas_clr = 1'b1;
            end
            S_MEASURE: begin
                if (!win_act_q) begin
                    if (sync != '0) begin
                        // First sync opens the window at t=0.
                        win_act_d = 1'b1;
                        win_cnt_d = TW'(1);
                        seen_d    = sync;
                        for (int i = 0; i < N_STREAMS; i++)
                            if (sync[i]) t_d[i] = '0;
                        close = &sync;
                    end else if (idle_cnt_q == TIMEOUT_LAST) begin
                        state_d    = S_ERROR;
                        err_code_d = 2'd1;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end else begin
                    // Only the first sync of each stream is timestamped.
                    for (int i = 0; i < N_STREAMS; i++)
                        if (sync[i] && !seen_q[i]) t_d[i] = win_cnt_q;
                    seen_d    = seen_q | sync;
                    close     = (&seen_d) || (win_cnt_q == MAX_T);
                    win_cnt_d = win_cnt_q + 1'b1;
                end

                if (close) begin
                    if (!(&seen_d)) begin
                        if (retry_q == RETRY_LIMIT) begin
                            state_d    = S_ERROR;
                            err_code_d = 2'd2;
                        end else begin
                            retry_d  = retry_q + 1'b1;
                            meas_clr = 1'b1;
                        end
                    end else begin
                        for (int i = 0; i < N_STREAMS; i++)
                            if (t_d[i] > t_max) t_max = t_d[i];
                        for (int i = 0; i < N_STREAMS; i++) begin
                            off_v = t_max - t_d[i];
                            if ((off_v & GRAN_MASK) != '0) bad_gran = 1'b1;
                            pulses_d[i] = off_v >> MUX_FACTOR_BITS;
                            if (pulses_d[i] != '0) all_zero = 1'b0;
                        end
                        if (bad_gran) begin
                            state_d    = S_ERROR;
                            err_code_d = 2'd3;
                            for (int i = 0; i < N_STREAMS; i++) pulses_d[i] = '0;
                        end else if (all_zero) begin
                            state_d = S_LOCKED;
                            retry_d = '0;
                        end else begin
                            state_d = S_PULSE;
                        end
                    end
                end
            end
            S_PULSE: begin
                if (af_hit) begin
                    state_d    = S_ERROR;
                    err_code_d = 2'd3;
                end else begin
                    for (int i = 0; i < N_STREAMS; i++)
                        if (pmask[i]) pulses_d[i] = pulses_q[i] - 1'b1;
                    state_d = S_SETTLE;
                    hold_d  = '0;
                end
            end
            S_SETTLE: begin
                // Keeps delay low long enough for the offsetter edge detector.
                if (hold_q == HOLD_LAST) begin
                    if (|pmask) begin
                        state_d = S_PULSE;
                    end else begin
                        state_d  = S_MEASURE;
                        meas_clr = 1'b1;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            S_LOCKED: begin
                if ((sync != '0) && !(&sync)) begin
`ifdef DTS_ALIGN_AUTO_RELOCK_EN
                    if (relock_q != 16'hFFFF) relock_d = relock_q + 16'd1;
                    state_d  = S_MEASURE;
                    retry_d  = '0;
                    meas_clr = 1'b1;
`else
                    state_d    = S_ERROR;
                    err_code_d = 2'd2;
`endif
                end
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Disable aborts everything, including a pending pulse or settle.
        if (!enable) begin
            state_d    = S_IDLE;
            err_code_d = 2'd0;
            retry_d    = '0;
            hold_d     = '0;
            meas_clr   = 1'b1;
            for (int i = 0; i < N_STREAMS; i++) pulses_d[i] = '0;
        end

        if (meas_clr) begin
            seen_d     = '0;
            win_act_d  = 1'b0;
            win_cnt_d  = '0;
            idle_cnt_d = '0;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            seen_q     <= '0;
            win_act_q  <= 1'b0;
            win_cnt_q  <= '0;
            idle_cnt_q <= '0;
            retry_q    <= '0;
            hold_q     <= '0;
            err_code_q <= 2'd0;
            relock_q   <= 16'd0;
            for (int i = 0; i < N_STREAMS; i++) begin
                t_q[i]      <= '0;
                pulses_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            seen_q     <= seen_d;
            win_act_q  <= win_act_d;
            win_cnt_q  <= win_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            retry_q    <= retry_d;
            hold_q     <= hold_d;
            err_code_q <= err_code_d;
            relock_q   <= relock_d;
            t_q        <= t_d;
            pulses_q   <= pulses_d;
        end
    end
endmodule

// File: tb/tb_dts_align_ctrl.sv
// Directed testbench for dts_align_ctrl. A small offsetter model generates
// periodic per-stream syncs; every observed delay pulse postpones that
// stream's next sync by one cycle.
module tb_dts_align_ctrl;
    localparam int N    = 4;
    localparam int HOLD = 8;
    localparam int TO   = 300;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic [N-1:0] sync;
    logic [N-1:0] af;
    logic [N-1:0] dly, dly_m1;
    logic         lck, lck_m1, err, err_m1;
    logic [1:0]   ec, ec_m1;
    logic [2:0]   st, st_m1;
    logic [15:0]  rc, rc_m1;

    int checks   = 0;
    int failures = 0;

    // Model state
    int         cnt [N];
    int         period;
    logic [N-1:0] act;
    bit         model_on = 0;
    bit         force_en = 0;
    logic [N-1:0] force_val;
    int         cyc = 0;
    int         pcnt [N];
    int         last_pulse, min_gap, first_sync_cyc;
    bit         any_pulse, m1_pulsed;

    always #5 clk = ~clk;

    dts_align_ctrl #(.N_STREAMS(N), .MUX_FACTOR_BITS(0), .MAX_OFFSET(63),
                     .HOLDOFF(HOLD), .SYNC_TIMEOUT(TO), .MAX_RETRY(3)) u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sync(sync), .almost_full(af),
        .delay(dly), .locked(lck), .error(err), .err_code(ec), .state(st),
        .relock_cnt(rc));

    dts_align_ctrl #(.N_STREAMS(N), .MUX_FACTOR_BITS(1), .MAX_OFFSET(63),
                     .HOLDOFF(HOLD), .SYNC_TIMEOUT(TO), .MAX_RETRY(3)) u_dut_m1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sync(sync), .almost_full(af),
        .delay(dly_m1), .locked(lck_m1), .error(err_m1), .err_code(ec_m1), .state(st_m1),
        .relock_cnt(rc_m1));

    // One cycle: drive sync for the next edge, sample outputs, advance model.
    task automatic tick();
        logic [N-1:0] s;
        @(negedge clk);
        cyc++;
        s = '0;
        if (model_on)
            for (int i = 0; i < N; i++) if (act[i] && cnt[i] == 0) s[i] = 1'b1;
        if (force_en) s = force_val;
        sync = s;
        if (s != '0 && first_sync_cyc < 0) first_sync_cyc = cyc;
        #1;
        if (dly != '0) begin
            any_pulse = 1;
            if (cyc - last_pulse < min_gap) min_gap = cyc - last_pulse;
            last_pulse = cyc;
        end
        for (int i = 0; i < N; i++) if (dly[i]) pcnt[i]++;
        if (dly_m1 != '0) m1_pulsed = 1;
        if (model_on)
            for (int i = 0; i < N; i++)
                cnt[i] = ((cnt[i] == 0) ? period - 1 : cnt[i] - 1) + (dly[i] ? 1 : 0);
    endtask

    task automatic model_init(input int b0, input int b1, input int b2, input int b3,
                              input int per, input logic [N-1:0] a);
        cnt[0] = 10 + b0; cnt[1] = 10 + b1; cnt[2] = 10 + b2; cnt[3] = 10 + b3;
        period = per; act = a;
        for (int i = 0; i < N; i++) pcnt[i] = 0;
        last_pulse = -1000; min_gap = 1000000; first_sync_cyc = -1;
        any_pulse = 0; m1_pulsed = 0; model_on = 1; force_en = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; enable = 1'b0; model_on = 0; force_en = 0;
        af = '0; sync = '0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int bound, output int n);
        n = 0;
        while (st !== s && n < bound) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; af = '0;
        model_init(0, 0, 0, 0, 5, 4'hF);
        repeat (4) tick();
        checks++; if (st !== 3'd0) begin failures++; $display("FAIL reset_state: got %0d want 0", st); end
        checks++; if (lck !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL reset_flags: locked=%0b error=%0b want 0 0", lck, err); end
        checks++; if (ec !== 2'd0) begin failures++; $display("FAIL reset_err_code: got %0d want 0", ec); end
        checks++; if (dly !== 4'h0) begin failures++; $display("FAIL reset_delay: got %h want 0", dly); end
        checks++; if (rc !== 16'd0) begin failures++; $display("FAIL reset_relock: got %0d want 0", rc); end
        $display("test_reset done");
    endtask

    task automatic test_aligned();
        int n, lat;
        do_reset();
        model_init(0, 0, 0, 0, 1000, 4'hF);
        enable = 1'b1;
        wait_state(3'd4, 60, n);
        lat = cyc - first_sync_cyc;
        checks++; if (st !== 3'd4) begin failures++; $display("FAIL aligned_lock: state=%0d want 4", st); end
        checks++; if (first_sync_cyc < 0 || lat > 2) begin failures++; $display("FAIL aligned_latency: got %0d cycles want <=2", lat); end
        repeat (1100) tick();
        checks++; if (lck !== 1'b1) begin failures++; $display("FAIL aligned_hold: locked=%0b want 1", lck); end
        checks++; if (any_pulse !== 1'b0) begin failures++; $display("FAIL aligned_no_delay: pulsed=%0b want 0", any_pulse); end
        $display("test_aligned latency=%0d", lat);
    endtask

    // off_i = max(t) - t_i gives the expected pulse counts per stream.
    task automatic test_skewed(input int b2, input int exp0, input int exp2);
        int n;
        do_reset();
        model_init(0, 3, b2, 3, 100, 4'hF);
        enable = 1'b1;
        wait_state(3'd4, 400, n);
        checks++; if (st !== 3'd4) begin failures++; $display("FAIL skew_lock: state=%0d want 4", st); end
        checks++; if (pcnt[0] != exp0) begin failures++; $display("FAIL skew_pulses0: got %0d want %0d", pcnt[0], exp0); end
        checks++; if (pcnt[2] != exp2) begin failures++; $display("FAIL skew_pulses2: got %0d want %0d", pcnt[2], exp2); end
        checks++; if (pcnt[1] != 0 || pcnt[3] != 0) begin failures++; $display("FAIL skew_pulses13: got %0d %0d want 0 0", pcnt[1], pcnt[3]); end
        checks++; if (min_gap < HOLD + 1) begin failures++; $display("FAIL skew_gap: got %0d want >=%0d", min_gap, HOLD + 1); end
        repeat (150) tick();
        checks++; if (lck !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL skew_hold: locked=%0b error=%0b want 1 0", lck, err); end
        $display("test_skewed t2=%0d pulses=%0d/%0d gap=%0d", b2, pcnt[0], pcnt[2], min_gap);
    endtask

    task automatic test_granularity();
        do_reset();
        model_init(0, 0, 0, 3, 100, 4'hF);
        enable = 1'b1;
        repeat (40) tick();
        checks++; if (st_m1 !== 3'd5 || err_m1 !== 1'b1) begin failures++; $display("FAIL gran_error: state=%0d error=%0b want 5 1", st_m1, err_m1); end
        checks++; if (ec_m1 !== 2'd3) begin failures++; $display("FAIL gran_code: got %0d want 3", ec_m1); end
        checks++; if (m1_pulsed !== 1'b0) begin failures++; $display("FAIL gran_no_delay: pulsed=%0b want 0", m1_pulsed); end
        $display("test_granularity code=%0d", ec_m1);
    endtask

    task automatic test_missing();
        do_reset();
        model_init(0, 0, 0, 0, 100, 4'b1011);
        enable = 1'b1;
        repeat (250) tick();
        checks++; if (st !== 3'd1 || err !== 1'b0) begin failures++; $display("FAIL missing_early: state=%0d error=%0b want 1 0", st, err); end
        repeat (200) tick();
        checks++; if (err !== 1'b1 || st !== 3'd5) begin failures++; $display("FAIL missing_error: state=%0d error=%0b want 5 1", st, err); end
        checks++; if (ec !== 2'd2) begin failures++; $display("FAIL missing_code: got %0d want 2", ec); end
        $display("test_missing code=%0d", ec);
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        enable = 1'b1;
        wait_state(3'd5, 400, n);
        checks++; if (n != TO + 1) begin failures++; $display("FAIL timeout_cycles: got %0d want %0d", n, TO + 1); end
        checks++; if (ec !== 2'd1 || err !== 1'b1) begin failures++; $display("FAIL timeout_code: code=%0d error=%0b want 1 1", ec, err); end
        $display("test_timeout cycles=%0d", n);
    endtask

    task automatic test_disable_settle();
        int n;
        do_reset();
        model_init(0, 3, 1, 3, 100, 4'hF);
        enable = 1'b1;
        wait_state(3'd3, 200, n);
        checks++; if (st !== 3'd3) begin failures++; $display("FAIL dis_reach_settle: state=%0d want 3", st); end
        enable = 1'b0;
        tick();
        checks++; if (st !== 3'd0) begin failures++; $display("FAIL dis_idle: state=%0d want 0", st); end
        checks++; if (dly !== 4'h0 || err !== 1'b0) begin failures++; $display("FAIL dis_outputs: delay=%h error=%0b want 0 0", dly, err); end
        any_pulse = 0;
        repeat (20) tick();
        checks++; if (any_pulse !== 1'b0 || st !== 3'd0) begin failures++; $display("FAIL dis_quiet: pulsed=%0b state=%0d want 0 0", any_pulse, st); end
        $display("test_disable_settle state=%0d", st);
    endtask

    task automatic test_almost_full();
        int n;
        do_reset();
        model_init(0, 3, 1, 3, 100, 4'hF);
        af = 4'hF;
        enable = 1'b1;
        wait_state(3'd5, 200, n);
        checks++; if (st !== 3'd5 || ec !== 2'd3) begin failures++; $display("FAIL af_error: state=%0d code=%0d want 5 3", st, ec); end
        checks++; if (any_pulse !== 1'b0) begin failures++; $display("FAIL af_no_delay: pulsed=%0b want 0", any_pulse); end
        af = '0;
        $display("test_almost_full code=%0d", ec);
    endtask

    task automatic test_lock_loss();
        int n;
        do_reset();
        model_init(0, 0, 0, 0, 1000, 4'hF);
        enable = 1'b1;
        wait_state(3'd4, 60, n);
        checks++; if (st !== 3'd4) begin failures++; $display("FAIL loss_prelock: state=%0d want 4", st); end
        force_en = 1; force_val = 4'b0010;
        tick();
        checks++; if (lck !== 1'b1) begin failures++; $display("FAIL loss_same_cycle: locked=%0b want 1", lck); end
        force_val = 4'b0000;
        tick();
        force_en = 0;
        checks++; if (lck !== 1'b0) begin failures++; $display("FAIL loss_drop: locked=%0b want 0", lck); end
`ifdef DTS_ALIGN_AUTO_RELOCK_EN
        checks++; if (st !== 3'd1 || err !== 1'b0) begin failures++; $display("FAIL loss_state: state=%0d error=%0b want 1 0", st, err); end
        checks++; if (rc !== 16'd1) begin failures++; $display("FAIL loss_relock: got %0d want 1", rc); end
`else
        checks++; if (st !== 3'd5 || ec !== 2'd2) begin failures++; $display("FAIL loss_state: state=%0d code=%0d want 5 2", st, ec); end
        checks++; if (rc !== 16'd0) begin failures++; $display("FAIL loss_relock: got %0d want 0", rc); end
`endif
        $display("test_lock_loss state=%0d relock=%0d", st, rc);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; sync = '0; af = '0; force_val = '0;
        test_reset();
        test_aligned();
        test_skewed(1, 3, 2);   // arrivals 0,3,1,3 -> offsets 3,0,2,0
        test_skewed(2, 3, 1);   // arrivals 0,3,2,3 -> offsets 3,0,1,0
        test_granularity();
        test_missing();
        test_timeout();
        test_disable_settle();
        test_almost_full();
        test_lock_loss();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
